// File: rtl/grid_pkg.sv
// Shared constants for the board-drawing blocks: the cell codes, the palette,
// the VGA adapter limits and the renderer's state encoding.
package grid_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'd0;
   localparam logic [1:0] CELL_O     = 2'd1;
   localparam logic [1:0] CELL_X     = 2'd2;

   localparam logic [2:0] COL_WHITE  = 3'b111;
   localparam logic [2:0] COL_LBLUE  = 3'b011;
   localparam logic [2:0] COL_PURPLE = 3'b101;
   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_YELLOW = 3'b110;

   localparam int VGA_W = 160;
   localparam int VGA_H = 120;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAW,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cell_colour_lut.sv
// Combinational cell-code to RGB palette lookup, shared by the screen blocks.
// Code 3 has no game meaning and is shown in red so a corrupted board is visible.
module cell_colour_lut
   import grid_pkg::*;
(
   input  logic [1:0] code,
   output logic [2:0] colour
);

   always_comb begin
      colour = COL_RED;
      case (code)
         CELL_EMPTY: colour = COL_WHITE;
         CELL_O:     colour = COL_LBLUE;
         CELL_X:     colour = COL_PURPLE;
         default:    colour = COL_RED;
      endcase
   end

endmodule

// File: rtl/grid_renderer.sv
// Draws an NxN board of 2-bit cell codes to the VGA adapter, one pixel per clock.
// Optional build macro CURSOR_HILITE_EN: yellow 1-pixel border on the cursor cell.
module grid_renderer
   import grid_pkg::*;
#(
   parameter int N        = 3,
   parameter int CELL     = 20,
   parameter int PITCH    = 30,
   parameter int ORIGIN_X = 37,
   parameter int ORIGIN_Y = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2*N*N-1:0] grid,
   input  logic [5:0]       cursor,
   output logic             busy,
   output logic             done,
   output logic [7:0]       x_out,
   output logic [6:0]       y_out,
   output logic [2:0]       colour_out,
   output logic             plot
);

   localparam int NCELLS = N * N;
   localparam int GW     = 2 * NCELLS;
   localparam int NW     = $clog2(N);
   localparam int PW     = (CELL > 1) ? $clog2(CELL) : 1;
   localparam int IW     = $clog2(NCELLS);

   localparam logic [NW-1:0] C_MAX  = NW'(N - 1);
   localparam logic [PW-1:0] PX_MAX = PW'(CELL - 1);

   if (N < 2 || N > 8) begin : g_bad_n
      $error("grid_renderer: N must be 2..8");
   end
   if (CELL < 1 || CELL > 32) begin : g_bad_cell
      $error("grid_renderer: CELL must be 1..32");
   end
   if (PITCH < CELL) begin : g_bad_pitch
      $error("grid_renderer: PITCH must be >= CELL");
   end
   if (ORIGIN_X + (N - 1) * PITCH + CELL - 1 > VGA_W - 1) begin : g_bad_x
      $error("grid_renderer: board exceeds screen width");
   end
   if (ORIGIN_Y + (N - 1) * PITCH + CELL - 1 > VGA_H - 1) begin : g_bad_y
      $error("grid_renderer: board exceeds screen height");
   end

   state_t          state_reg, state_next;
   logic [NW-1:0]   r_reg, r_next, c_reg, c_next;
   logic [PW-1:0]   py_reg, py_next, px_reg, px_next;
   logic [7:0]      cell_x_reg, cell_x_next;
   logic [6:0]      cell_y_reg, cell_y_next;
   logic [GW-1:0]   snap_reg, snap_next;
   logic [7:0]      x_reg, x_next;
   logic [6:0]      y_reg, y_next;
   logic [2:0]      colour_reg, colour_next;
   logic            plot_reg, plot_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            accept;
   logic [IW-1:0]   idx_next;
   logic [1:0]      code_next;
   logic [2:0]      cell_colour;
   logic [1:0]      codes [NCELLS];

   assign accept = (state_reg == ST_IDLE) && start;

   // Cell origins are stepped by PITCH rather than multiplied out per pixel.
   always_comb begin
      state_next  = state_reg;
      r_next      = r_reg;
      c_next      = c_reg;
      py_next     = py_reg;
      px_next     = px_reg;
      cell_x_next = cell_x_reg;
      cell_y_next = cell_y_reg;
      snap_next   = snap_reg;
      plot_next   = 1'b0;
      busy_next   = 1'b0;
      done_next   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next  = ST_DRAW;
               r_next      = '0;
               c_next      = '0;
               py_next     = '0;
               px_next     = '0;
               cell_x_next = 8'(ORIGIN_X);
               cell_y_next = 7'(ORIGIN_Y);
               snap_next   = grid;
               plot_next   = 1'b1;
               busy_next   = 1'b1;
            end
         end
         ST_DRAW: begin
            busy_next = 1'b1;
            plot_next = 1'b1;
            if (px_reg != PX_MAX) begin
               px_next = px_reg + PW'(1);
            end else begin
               px_next = '0;
               if (py_reg != PX_MAX) begin
                  py_next = py_reg + PW'(1);
               end else begin
                  py_next = '0;
                  if (c_reg != C_MAX) begin
                     c_next      = c_reg + NW'(1);
                     cell_x_next = cell_x_reg + 8'(PITCH);
                  end else begin
                     c_next      = '0;
                     cell_x_next = 8'(ORIGIN_X);
                     if (r_reg != C_MAX) begin
                        r_next      = r_reg + NW'(1);
                        cell_y_next = cell_y_reg + 7'(PITCH);
                     end else begin
                        r_next      = '0;
                        cell_y_next = 7'(ORIGIN_Y);
                        state_next  = ST_DONE;
                        plot_next   = 1'b0;
                        done_next   = 1'b1;
                     end
                  end
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Unpack the snapshot so cell k sits at codes[k]; cell (0,0) is the MSB pair.
   for (genvar gi = 0; gi < NCELLS; gi++) begin : g_codes
      assign codes[gi] = snap_next[GW-1-2*gi -: 2];
   end

   assign idx_next  = IW'(int'(r_next) * N + int'(c_next));
   assign code_next = codes[idx_next];
   assign x_next    = cell_x_next + 8'(px_next);
   assign y_next    = cell_y_next + 7'(py_next);

   cell_colour_lut u_lut (
      .code   (code_next),
      .colour (cell_colour)
   );

`ifdef CURSOR_HILITE_EN
   logic [5:0] cursor_reg, cursor_next;
   logic       on_border;

   assign cursor_next = accept ? cursor : cursor_reg;
   assign on_border   = (px_next == '0) || (px_next == PX_MAX) ||
                        (py_next == '0) || (py_next == PX_MAX);

   // Cell indices never reach N*N, so an out-of-range cursor matches nothing.
   always_comb begin
      colour_next = cell_colour;
      if (on_border && (cursor_next == 6'(idx_next))) begin
         colour_next = COL_YELLOW;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cursor_reg <= '0;
      end else begin
         cursor_reg <= cursor_next;
      end
   end
`else
   logic unused_cursor;

   assign unused_cursor = ^{cursor, accept};

   always_comb begin
      colour_next = cell_colour;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         r_reg      <= '0;
         c_reg      <= '0;
         py_reg     <= '0;
         px_reg     <= '0;
         cell_x_reg <= '0;
         cell_y_reg <= '0;
         snap_reg   <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         colour_reg <= '0;
         plot_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         r_reg      <= r_next;
         c_reg      <= c_next;
         py_reg     <= py_next;
         px_reg     <= px_next;
         cell_x_reg <= cell_x_next;
         cell_y_reg <= cell_y_next;
         snap_reg   <= snap_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         colour_reg <= colour_next;
         plot_reg   <= plot_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign plot       = plot_reg;
   assign x_out      = x_reg;
   assign y_out      = y_reg;
   assign colour_out = colour_reg;

endmodule
